ifu_align_queue: RTL and testbench

Parametrised fetch-alignment queue between the I-cache/MMU fetch return and the IF/ID register. It accepts aligned fetch packets of `FETCH_BYTES` bytes and buffers them as halfwords. It extracts one RVC (16-bit) or RVI (32-bit) instruction per cycle, including instructions that straddle packet boundaries, and tags instruction page faults per halfword. It replaces the single-register cross-boundary halfword refill scheme with a `DEPTH`-halfword queue and a decoupled valid/ready handshake.

---
 rtl/ifu_align_queue.sv | 108 ++++++++++
 tb/tb_ifu_align_queue.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/ifu_align_queue.sv
// Fetch-alignment queue: buffers fetch packets as halfwords and emits one RVC/RVI
// instruction per cycle, including instructions that straddle packet boundaries.
module ifu_align_queue #(
    parameter int          FETCH_BYTES = 4,
    parameter int          DEPTH       = 8,
    parameter logic [31:0] RESET_PC    = 32'h8000_0000
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush_i,
    input  logic                       fetch_valid_i,
    output logic                       fetch_ready_o,
    input  logic [31:0]                fetch_addr_i,
    input  logic [8*FETCH_BYTES-1:0]   fetch_data_i,
    input  logic                       fetch_fault_i,
    output logic                       inst_valid_o,
    input  logic                       inst_ready_i,
    output logic [31:0]                inst_addr_o,
    output logic [31:0]                inst_data_o,
    output logic                       inst_rvc_o,
    output logic                       inst_fault_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int HW   = FETCH_BYTES / 2;
    localparam int OFFW = $clog2(FETCH_BYTES);
    localparam int PW   = $clog2(DEPTH);
    localparam int CW   = PW + 1;

    logic [15:0]      hw_mem [DEPTH];
    logic [DEPTH-1:0] fault_mem;
    logic [PW-1:0]    head;
    logic [PW-1:0]    tail;
    logic [CW-1:0]    count;
    logic [31:0]      head_pc;

    logic [OFFW-2:0]  off;
    logic [CW-1:0]    n_push;
    logic [CW-1:0]    n_pop;
    logic [CW-1:0]    space;
    logic [15:0]      h0;
    logic [15:0]      h1;
    logic             f0;
    logic             f1;
    logic             need_two;
    logic             push;
    logic             pop;

    assign off    = fetch_addr_i[OFFW-1:1];
    assign space  = CW'(DEPTH) - count;

    assign fetch_ready_o = (space >= CW'(HW));
    assign count_o       = count;

    assign h0 = hw_mem[head];
    assign h1 = hw_mem[head + PW'(1)];
    assign f0 = fault_mem[head];
    assign f1 = fault_mem[head + PW'(1)];

    // A faulted head halfword is emitted alone so the fault is reported at its own PC.
    assign need_two     = !f0 && (h0[1:0] == 2'b11);
    assign inst_valid_o = need_two ? (count >= CW'(2)) : (count >= CW'(1));
    assign inst_addr_o  = head_pc;
    assign inst_rvc_o   = inst_valid_o && !need_two;
    assign inst_fault_o = inst_valid_o && (need_two ? f1 : f0);
    assign inst_data_o  = !inst_valid_o ? 32'h0 :
                          need_two      ? {h1, h0} : {16'h0, h0};

    assign push   = fetch_valid_i && fetch_ready_o && !flush_i;
    assign pop    = inst_valid_o && inst_ready_i && !flush_i;
    assign n_push = push ? (CW'(HW) - CW'(off)) : CW'(0);
    assign n_pop  = !pop ? CW'(0) : (need_two ? CW'(2) : CW'(1));

    // Halfword storage carries no reset; occupancy is tracked solely by count.
    always_ff @(posedge clk) begin
        if (push) begin
            for (int i = 0; i < HW; i++) begin
                if (i >= int'(off)) begin
                    hw_mem[tail + PW'(i - int'(off))]    <= fetch_data_i[16*i +: 16];
                    fault_mem[tail + PW'(i - int'(off))] <= fetch_fault_i;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head    <= '0;
            tail    <= '0;
            count   <= '0;
            head_pc <= RESET_PC;
        end else if (flush_i) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            tail  <= tail + PW'(n_push);
            head  <= head + PW'(n_pop);
            count <= count + n_push - n_pop;
            // An empty queue cannot pop, so a load and an advance never coincide.
            if (push && count == '0)
                head_pc <= fetch_addr_i;
            else if (pop)
                head_pc <= head_pc + (need_two ? 32'd4 : 32'd2);
        end
    end

endmodule

// File: tb/tb_ifu_align_queue.sv
// Directed testbench for ifu_align_queue (FETCH_BYTES=4, DEPTH=8) with hand-computed expectations.
module tb_ifu_align_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush_i;
    logic        fetch_valid_i;
    logic        fetch_ready_o;
    logic [31:0] fetch_addr_i;
    logic [31:0] fetch_data_i;
    logic        fetch_fault_i;
    logic        inst_valid_o;
    logic        inst_ready_i;
    logic [31:0] inst_addr_o;
    logic [31:0] inst_data_o;
    logic        inst_rvc_o;
    logic        inst_fault_o;
    logic [3:0]  count_o;

    int checks   = 0;
    int failures = 0;

    ifu_align_queue #(.FETCH_BYTES(4), .DEPTH(8), .RESET_PC(32'h8000_0000)) dut (
        .clk(clk), .rst(rst), .flush_i(flush_i),
        .fetch_valid_i(fetch_valid_i), .fetch_ready_o(fetch_ready_o),
        .fetch_addr_i(fetch_addr_i), .fetch_data_i(fetch_data_i), .fetch_fault_i(fetch_fault_i),
        .inst_valid_o(inst_valid_o), .inst_ready_i(inst_ready_i),
        .inst_addr_o(inst_addr_o), .inst_data_o(inst_data_o),
        .inst_rvc_o(inst_rvc_o), .inst_fault_o(inst_fault_o), .count_o(count_o)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_pkt(input logic [31:0] addr, input logic [31:0] data, input logic fault);
        fetch_valid_i = 1'b1;
        fetch_addr_i  = addr;
        fetch_data_i  = data;
        fetch_fault_i = fault;
        step();
        fetch_valid_i = 1'b0;
        fetch_fault_i = 1'b0;
    endtask

    task automatic pop_one();
        inst_ready_i = 1'b1;
        step();
        inst_ready_i = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; flush_i = 0; fetch_valid_i = 0; fetch_addr_i = 0;
        fetch_data_i = 0; fetch_fault_i = 0; inst_ready_i = 0;
        #12;
        checks++; if (inst_valid_o !== 1'b0) begin failures++; $display("FAIL rst_valid got=%b exp=0", inst_valid_o); end
        checks++; if (inst_addr_o !== 32'h8000_0000) begin failures++; $display("FAIL rst_addr got=%h exp=80000000", inst_addr_o); end
        checks++; if (fetch_ready_o !== 1'b1) begin failures++; $display("FAIL rst_ready got=%b exp=1", fetch_ready_o); end
        checks++; if (count_o !== 4'd0) begin failures++; $display("FAIL rst_count got=%0d exp=0", count_o); end
        checks++; if ({inst_data_o, inst_rvc_o, inst_fault_o} !== 34'h0) begin failures++; $display("FAIL rst_data got=%h/%b/%b exp=0", inst_data_o, inst_rvc_o, inst_fault_o); end
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic test_single_rvi();
        push_pkt(32'h8000_0000, 32'h0000_0513, 1'b0);
        checks++; if (inst_valid_o !== 1'b1) begin failures++; $display("FAIL rvi_valid got=%b exp=1", inst_valid_o); end
        checks++; if (inst_addr_o !== 32'h8000_0000) begin failures++; $display("FAIL rvi_addr got=%h exp=80000000", inst_addr_o); end
        checks++; if (inst_data_o !== 32'h0000_0513) begin failures++; $display("FAIL rvi_data got=%h exp=00000513", inst_data_o); end
        checks++; if (inst_rvc_o !== 1'b0) begin failures++; $display("FAIL rvi_rvc got=%b exp=0", inst_rvc_o); end
        checks++; if (count_o !== 4'd2) begin failures++; $display("FAIL rvi_count got=%0d exp=2", count_o); end
        pop_one();
        checks++; if (count_o !== 4'd0) begin failures++; $display("FAIL rvi_count_after got=%0d exp=0", count_o); end
        checks++; if (inst_valid_o !== 1'b0) begin failures++; $display("FAIL rvi_valid_after got=%b exp=0", inst_valid_o); end
    endtask

    task automatic test_two_rvc();
        push_pkt(32'h8000_0000, 32'h4501_4581, 1'b0);
        checks++; if (inst_data_o !== 32'h0000_4581) begin failures++; $display("FAIL rvc0_data got=%h exp=00004581", inst_data_o); end
        checks++; if (inst_addr_o !== 32'h8000_0000) begin failures++; $display("FAIL rvc0_addr got=%h exp=80000000", inst_addr_o); end
        checks++; if (inst_rvc_o !== 1'b1) begin failures++; $display("FAIL rvc0_rvc got=%b exp=1", inst_rvc_o); end
        inst_ready_i = 1'b1;
        step();
        checks++; if (inst_valid_o !== 1'b1) begin failures++; $display("FAIL rvc1_valid got=%b exp=1", inst_valid_o); end
        checks++; if (inst_data_o !== 32'h0000_4501) begin failures++; $display("FAIL rvc1_data got=%h exp=00004501", inst_data_o); end
        checks++; if (inst_addr_o !== 32'h8000_0002) begin failures++; $display("FAIL rvc1_addr got=%h exp=80000002", inst_addr_o); end
        checks++; if (inst_rvc_o !== 1'b1) begin failures++; $display("FAIL rvc1_rvc got=%b exp=1", inst_rvc_o); end
        step();
        inst_ready_i = 1'b0;
        checks++; if (count_o !== 4'd0) begin failures++; $display("FAIL rvc_count_after got=%0d exp=0", count_o); end
    endtask

    task automatic test_straddle();
        push_pkt(32'h8000_0000, 32'h0513_4581, 1'b0);
        checks++; if (inst_data_o !== 32'h0000_4581) begin failures++; $display("FAIL str_first got=%h exp=00004581", inst_data_o); end
        pop_one();
        checks++; if (inst_valid_o !== 1'b0) begin failures++; $display("FAIL str_wait_valid got=%b exp=0", inst_valid_o); end
        checks++; if (count_o !== 4'd1) begin failures++; $display("FAIL str_wait_count got=%0d exp=1", count_o); end
        checks++; if (inst_data_o !== 32'h0) begin failures++; $display("FAIL str_wait_data got=%h exp=0", inst_data_o); end
        push_pkt(32'h8000_0004, 32'h4501_0000, 1'b0);
        checks++; if (inst_valid_o !== 1'b1) begin failures++; $display("FAIL str_valid got=%b exp=1", inst_valid_o); end
        checks++; if (inst_data_o !== 32'h0000_0513) begin failures++; $display("FAIL str_data got=%h exp=00000513", inst_data_o); end
        checks++; if (inst_addr_o !== 32'h8000_0002) begin failures++; $display("FAIL str_addr got=%h exp=80000002", inst_addr_o); end
        checks++; if (inst_rvc_o !== 1'b0) begin failures++; $display("FAIL str_rvc got=%b exp=0", inst_rvc_o); end
        checks++; if (count_o !== 4'd3) begin failures++; $display("FAIL str_count got=%0d exp=3", count_o); end
        pop_one();
        checks++; if (inst_data_o !== 32'h0000_4501) begin failures++; $display("FAIL str_tail_data got=%h exp=00004501", inst_data_o); end
        checks++; if (inst_addr_o !== 32'h8000_0006) begin failures++; $display("FAIL str_tail_addr got=%h exp=80000006", inst_addr_o); end
        checks++; if (inst_rvc_o !== 1'b1) begin failures++; $display("FAIL str_tail_rvc got=%b exp=1", inst_rvc_o); end
        pop_one();
        checks++; if (count_o !== 4'd0) begin failures++; $display("FAIL str_count_after got=%0d exp=0", count_o); end
    endtask

    task automatic test_flush_redirect();
        push_pkt(32'h8000_0010, 32'h0513_4581, 1'b0);
        pop_one();
        flush_i = 1'b1; inst_ready_i = 1'b1; fetch_valid_i = 1'b1;
        fetch_addr_i = 32'h8000_0014; fetch_data_i = 32'h1111_1111;
        step();
        flush_i = 1'b0; inst_ready_i = 1'b0; fetch_valid_i = 1'b0;
        checks++; if (inst_valid_o !== 1'b0) begin failures++; $display("FAIL fl_valid got=%b exp=0", inst_valid_o); end
        checks++; if (count_o !== 4'd0) begin failures++; $display("FAIL fl_count got=%0d exp=0", count_o); end
        checks++; if (fetch_ready_o !== 1'b1) begin failures++; $display("FAIL fl_ready got=%b exp=1", fetch_ready_o); end
        push_pkt(32'h8000_0102, 32'h4581_FFFF, 1'b0);
        checks++; if (count_o !== 4'd1) begin failures++; $display("FAIL rd_count got=%0d exp=1", count_o); end
        checks++; if (inst_valid_o !== 1'b1) begin failures++; $display("FAIL rd_valid got=%b exp=1", inst_valid_o); end
        checks++; if (inst_addr_o !== 32'h8000_0102) begin failures++; $display("FAIL rd_addr got=%h exp=80000102", inst_addr_o); end
        checks++; if (inst_data_o !== 32'h0000_4581) begin failures++; $display("FAIL rd_data got=%h exp=00004581", inst_data_o); end
        checks++; if (inst_rvc_o !== 1'b1) begin failures++; $display("FAIL rd_rvc got=%b exp=1", inst_rvc_o); end
        pop_one();
        checks++; if (inst_valid_o !== 1'b0 || count_o !== 4'd0) begin failures++; $display("FAIL rd_after got=%b/%0d exp=0/0", inst_valid_o, count_o); end
    endtask

    task automatic test_backpressure_wrap();
        logic [31:0] pkts [4];
        logic [3:0]  exp_cnt  [9];
        logic [31:0] exp_addr [9];
        logic [31:0] exp_data [9];
        logic        exp_rvc  [9];
        pkts = '{32'h4005_4001, 32'h00AA_0513, 32'h4011_400D, 32'h4019_4015};
        exp_cnt  = '{4'd8, 4'd7, 4'd6, 4'd6, 4'd5, 4'd4, 4'd3, 4'd2, 4'd1};
        exp_addr = '{32'h8000_0200, 32'h8000_0202, 32'h8000_0204, 32'h8000_0208, 32'h8000_020A,
                     32'h8000_020C, 32'h8000_020E, 32'h8000_0210, 32'h8000_0212};
        exp_data = '{32'h4001, 32'h4005, 32'h00AA_0513, 32'h400D, 32'h4011,
                     32'h4015, 32'h4019, 32'h401D, 32'h4021};
        exp_rvc  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        for (int i = 0; i < 4; i++) begin
            checks++; if (fetch_ready_o !== 1'b1) begin failures++; $display("FAIL bp_ready_%0d got=%b exp=1", i, fetch_ready_o); end
            push_pkt(32'h8000_0200 + 32'(4*i), pkts[i], 1'b0);
        end
        checks++; if (count_o !== 4'd8) begin failures++; $display("FAIL bp_full_count got=%0d exp=8", count_o); end
        checks++; if (fetch_ready_o !== 1'b0) begin failures++; $display("FAIL bp_full_ready got=%b exp=0", fetch_ready_o); end
        fetch_valid_i = 1'b1; fetch_addr_i = 32'h8000_0210; fetch_data_i = 32'h4021_401D;
        step();
        checks++; if (count_o !== 4'd8) begin failures++; $display("FAIL bp_blocked_count got=%0d exp=8", count_o); end
        inst_ready_i = 1'b1;
        for (int i = 0; i < 9; i++) begin
            if (i == 3) fetch_valid_i = 1'b0;
            checks++; if (count_o !== exp_cnt[i]) begin failures++; $display("FAIL wr_count_%0d got=%0d exp=%0d", i, count_o, exp_cnt[i]); end
            checks++; if (fetch_ready_o !== (exp_cnt[i] <= 4'd6)) begin failures++; $display("FAIL wr_ready_%0d got=%b", i, fetch_ready_o); end
            checks++; if (inst_valid_o !== 1'b1) begin failures++; $display("FAIL wr_valid_%0d got=%b exp=1", i, inst_valid_o); end
            checks++; if (inst_addr_o !== exp_addr[i]) begin failures++; $display("FAIL wr_addr_%0d got=%h exp=%h", i, inst_addr_o, exp_addr[i]); end
            checks++; if (inst_data_o !== exp_data[i]) begin failures++; $display("FAIL wr_data_%0d got=%h exp=%h", i, inst_data_o, exp_data[i]); end
            checks++; if (inst_rvc_o !== exp_rvc[i]) begin failures++; $display("FAIL wr_rvc_%0d got=%b exp=%b", i, inst_rvc_o, exp_rvc[i]); end
            step();
        end
        inst_ready_i = 1'b0;
        checks++; if (count_o !== 4'd0 || inst_valid_o !== 1'b0) begin failures++; $display("FAIL wr_empty got=%0d/%b exp=0/0", count_o, inst_valid_o); end
    endtask

    task automatic test_fault();
        push_pkt(32'h8000_0004, 32'h4501_4581, 1'b1);
        checks++; if (inst_fault_o !== 1'b1 || inst_rvc_o !== 1'b1) begin failures++; $display("FAIL flt0_bits got=%b/%b exp=1/1", inst_fault_o, inst_rvc_o); end
        checks++; if (inst_addr_o !== 32'h8000_0004) begin failures++; $display("FAIL flt0_addr got=%h exp=80000004", inst_addr_o); end
        checks++; if (inst_data_o !== 32'h0000_4581) begin failures++; $display("FAIL flt0_data got=%h exp=00004581", inst_data_o); end
        pop_one();
        checks++; if (inst_fault_o !== 1'b1 || inst_rvc_o !== 1'b1) begin failures++; $display("FAIL flt1_bits got=%b/%b exp=1/1", inst_fault_o, inst_rvc_o); end
        checks++; if (inst_addr_o !== 32'h8000_0006) begin failures++; $display("FAIL flt1_addr got=%h exp=80000006", inst_addr_o); end
        pop_one();
        push_pkt(32'h8000_0022, 32'h0513_FFFF, 1'b0);
        checks++; if (inst_valid_o !== 1'b0 || inst_fault_o !== 1'b0) begin failures++; $display("FAIL fup_wait got=%b/%b exp=0/0", inst_valid_o, inst_fault_o); end
        push_pkt(32'h8000_0024, 32'h4501_00AA, 1'b1);
        checks++; if (inst_valid_o !== 1'b1) begin failures++; $display("FAIL fup_valid got=%b exp=1", inst_valid_o); end
        checks++; if (inst_data_o !== 32'h00AA_0513) begin failures++; $display("FAIL fup_data got=%h exp=00aa0513", inst_data_o); end
        checks++; if (inst_fault_o !== 1'b1 || inst_rvc_o !== 1'b0) begin failures++; $display("FAIL fup_bits got=%b/%b exp=1/0", inst_fault_o, inst_rvc_o); end
        checks++; if (inst_addr_o !== 32'h8000_0022) begin failures++; $display("FAIL fup_addr got=%h exp=80000022", inst_addr_o); end
        pop_one();
        checks++; if (inst_data_o !== 32'h0000_4501 || inst_fault_o !== 1'b1) begin failures++; $display("FAIL fup_tail got=%h/%b exp=00004501/1", inst_data_o, inst_fault_o); end
        pop_one();
    endtask

    task automatic test_async_reset();
        push_pkt(32'h8000_0040, 32'h0000_0513, 1'b0);
        checks++; if (inst_valid_o !== 1'b1) begin failures++; $display("FAIL ar_pre_valid got=%b exp=1", inst_valid_o); end
        #2 rst = 1'b1;
        #1;
        checks++; if (inst_valid_o !== 1'b0 || count_o !== 4'd0) begin failures++; $display("FAIL ar_clear got=%b/%0d exp=0/0", inst_valid_o, count_o); end
        checks++; if (inst_addr_o !== 32'h8000_0000) begin failures++; $display("FAIL ar_addr got=%h exp=80000000", inst_addr_o); end
        step();
        rst = 1'b0;
        step();
    endtask

    initial begin
        test_reset();
        test_single_rvi();
        test_two_rvc();
        test_straddle();
        test_flush_redirect();
        test_backpressure_wrap();
        test_fault();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
